conf_loader: RTL and testbench
==============================

# conf_loader

Host-side initiator for the core's memory configuration port. Parses a byte-stream command protocol (from a UART or debug bridge) and drives `conf_sel`, `conf_wren`, `conf_rden`, `conf_addr` and `conf_wdata` to load and read back program memory. Read results, and optionally the core's print characters, return on an outgoing byte stream. Sits between the host link and the core top: it drives the conf port and consumes the print port.

## Interface
- `RD_LAT`, default 1: cycles from the `conf_rden` pulse to valid `conf_rdata`. Legal range is 1–7.
- `clk` in 1: system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: command byte valid.
- `rx_data` in 8: command byte.
- `rx_ready` out 1: byte accepted when `rx_valid & rx_ready`.
- `tx_valid` out 1: response byte valid.
- `tx_data` out 8: response byte.
- `tx_ready` in 1: byte consumed when `tx_valid & tx_ready`.
- `conf_sel` out 1: holds the core in reset and grants the host the memory.
- `conf_wren` out 1: one-cycle write strobe.
- `conf_rden` out 1: one-cycle read strobe.
- `conf_addr` out 32: word address.
- `conf_wdata` out 32: write data.
- `conf_rdata` in 32: read data.
- `print_valid` in 1: print character strobe from the core.
- `print_value` in 8: print character.
- `cmd_err` out 1: one-cycle pulse on a rejected command.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **Opcodes** (first byte of each command):
  - 0x01 WRITE: 4 address bytes then 4 data bytes, little-endian.
  - 0x02 READ: 4 address bytes; the response is 4 data bytes, little-endian.
  - 0x03 SEL_ON: sets `conf_sel` to 1.
  - 0x04 SEL_OFF: sets `conf_sel` to 0, releasing the core.
  - Any other opcode: `cmd_err` pulses, the byte is dropped, and the state stays IDLE.
- **States:**
  - IDLE: on opcode 0x01 or 0x02 → ADDR. On 0x03 or 0x04, `conf_sel` updates the next cycle and the state stays IDLE.
  - ADDR: collects 4 bytes, byte 0 into `[7:0]`. WRITE → DATA; READ → RD.
  - DATA: collects 4 bytes → WR.
  - WR: `conf_wren` is 1 for exactly one cycle → IDLE.
  - RD: `conf_rden` is 1 for exactly one cycle → RWAIT.
  - RWAIT: counts `RD_LAT` cycles, captures `conf_rdata` → RESP.
  - RESP: sends 4 bytes, LSB first → IDLE after the last handshake.
- `rx_ready` is 1 only in IDLE, ADDR and DATA.
- **WRITE or READ received while `conf_sel`=0:**
  - The payload is still consumed.
  - No strobe is issued.
  - `cmd_err` pulses in the cycle after the last payload byte.
  - READ returns no response.
- `conf_addr` and `conf_wdata` hold their last values outside strobes; they are not cleared after use.
- `conf_sel` is never changed mid-command, because opcodes are parsed only in IDLE.

## Timing
- **Reset values:** `rx_ready`=0, `tx_valid`=0, `tx_data`=0, `conf_sel`=0, `conf_wren`=0, `conf_rden`=0, `conf_addr`=0, `conf_wdata`=0, `cmd_err`=0, `busy`=0, state IDLE. `rx_ready` goes to 1 in the first cycle after reset deasserts.
- **WRITE:** `conf_wren` is high in the cycle after the 8th payload handshake, with `conf_addr` and `conf_wdata` already stable. The next opcode is accepted 1 cycle later.
- **READ:**
  - `conf_rden` is high in the cycle after the 4th address handshake.
  - `conf_rdata` is sampled at the clock edge `RD_LAT` cycles after the `conf_rden` cycle.
  - `tx_valid` rises in the next cycle.
- **TX:** `tx_data` is held stable while `tx_valid & !tx_ready`. No byte may be skipped or duplicated.
- **Reset mid-command:** the partial command is discarded, all outputs return to their reset values, and `conf_sel` drops to 0.

## Configuration
- **`LOADER_PRINT_FWD_EN` defined:**
  - Each `print_valid` pulse loads `print_value` into a 1-entry holding register.
  - The register is sent on tx only in IDLE, when no read response is pending. Read responses therefore have priority and are never interleaved with print bytes.
  - If `print_valid` arrives while the register is full, the new character is dropped and a 16-bit saturating drop counter increments.
  - Sending and loading in the same cycle is legal: the new character is kept.
- **`LOADER_PRINT_FWD_EN` not defined:** `print_valid` and `print_value` are ignored, with no holding register and no counter.

## Test plan
- SEL_ON (0x03), then WRITE 01 10 00 00 00 EF BE AD DE → `conf_sel`=1, a single `conf_wren` pulse with `conf_addr`=0x00000010, `conf_wdata`=0xDEADBEEF.
- With `conf_sel`=1 and `RD_LAT`=1, READ 02 10 00 00 00, model returns 0xDEADBEEF → tx bytes EF, BE, AD, DE. Repeat with `tx_ready` toggling every other cycle → identical bytes with no loss.
- With `conf_sel`=0, WRITE to 0x20 → no `conf_wren`, `cmd_err` pulses once, and the following SEL_ON is accepted normally.
- Opcode 0x7F → `cmd_err` pulse, state stays IDLE, `busy`=0.
- `resetn` low after 2 address bytes of a READ → all outputs at reset values and no `conf_rden`. After release, a full READ works.
- With `LOADER_PRINT_FWD_EN`, `conf_sel`=0 and `tx_ready`=0, two `print_valid` pulses 0x48 then 0x49 → tx presents 0x48 and the drop counter reads 1. Then `tx_ready`=1 → 0x48 is sent once.

Source files
------------

// File: rtl/conf_loader.sv
// Byte-stream command parser driving the core's memory configuration port.
// Optional print-character forwarding on tx is enabled by LOADER_PRINT_FWD_EN.
module conf_loader #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        conf_sel,
    output logic        conf_wren,
    output logic        conf_rden,
    output logic [31:0] conf_addr,
    output logic [31:0] conf_wdata,
    input  logic [31:0] conf_rdata,
    input  logic        print_valid,
    input  logic [7:0]  print_value,
    output logic        cmd_err,
    output logic        busy
);

    localparam int unsigned LAT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_WR, S_RD, S_RWAIT, S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               is_rd_q, is_rd_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [31:0]        rbuf_q, rbuf_d;
    logic [2:0]         rcnt_q, rcnt_d;
    logic               rx_ready_q, rx_ready_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               sel_q, sel_d;
    logic               wren_q, wren_d;
    logic               rden_q, rden_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               cmd_err_q, cmd_err_d;
    logic               busy_q, busy_d;
    logic               rx_hs_c, tx_hs_c, tx_free_c;

`ifdef LOADER_PRINT_FWD_EN
    logic               pr_full_q, pr_full_d;
    logic               pr_on_tx_q, pr_on_tx_d;
    logic [7:0]         pr_data_q, pr_data_d;
    logic [15:0]        drop_q, drop_d;
    logic               pr_sent_c;
`else
    logic               unused_print_c;
    assign unused_print_c = ^{print_valid, print_value};
`endif

    assign rx_hs_c   = rx_valid & rx_ready_q;
    assign tx_hs_c   = tx_valid_q & tx_ready;
    assign tx_free_c = ~tx_valid_q | tx_ready;

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_rd_d    = is_rd_q;
        lat_d      = lat_q;
        rbuf_d     = rbuf_q;
        rcnt_d     = rcnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        sel_d      = sel_q;
        wren_d     = 1'b0;
        rden_d     = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cmd_err_d  = 1'b0;
`ifdef LOADER_PRINT_FWD_EN
        pr_full_d  = pr_full_q;
        pr_on_tx_d = pr_on_tx_q;
        pr_data_d  = pr_data_q;
        drop_d     = drop_q;
        pr_sent_c  = tx_hs_c & pr_on_tx_q;
`endif

        if (tx_hs_c) tx_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_hs_c) begin
                    case (rx_data)
                        8'h01: begin state_d = S_ADDR; is_rd_d = 1'b0; cnt_d = 2'd0; end
                        8'h02: begin state_d = S_ADDR; is_rd_d = 1'b1; cnt_d = 2'd0; end
                        8'h03: sel_d = 1'b1;
                        8'h04: sel_d = 1'b0;
                        default: cmd_err_d = 1'b1;
                    endcase
                end
            end
            S_ADDR: begin
                if (rx_hs_c) begin
                    addr_d[{cnt_q, 3'b000} +: 8] = rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (!is_rd_q) begin
                            state_d = S_DATA;
                        end else if (sel_q) begin
                            state_d = S_RD;
                            rden_d  = 1'b1;
                        end else begin
                            state_d   = S_IDLE;
                            cmd_err_d = 1'b1;
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_hs_c) begin
                    wdata_d[{cnt_q, 3'b000} +: 8] = rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (sel_q) begin
                            state_d = S_WR;
                            wren_d  = 1'b1;
                        end else begin
                            state_d   = S_IDLE;
                            cmd_err_d = 1'b1;
                        end
                    end
                end
            end
            S_WR: state_d = S_IDLE;
            S_RD: begin
                state_d = S_RWAIT;
                lat_d   = LAT_W'(1);
            end
            S_RWAIT: begin
                if (lat_q == LAT_W'(RD_LAT)) begin
                    rbuf_d  = conf_rdata;
                    state_d = S_RESP;
                    // Launch byte 0 immediately unless a print byte still occupies tx
                    if (tx_free_c) begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = conf_rdata[7:0];
                        rcnt_d     = 3'd1;
                    end else begin
                        rcnt_d     = 3'd0;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_RESP: begin
                if (tx_free_c) begin
                    if (rcnt_q < 3'd4) begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = rbuf_q[{rcnt_q[1:0], 3'b000} +: 8];
                        rcnt_d     = rcnt_q + 3'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef LOADER_PRINT_FWD_EN
        // Holding register stays full until its byte is handshaken on tx
        if (pr_sent_c) begin
            pr_full_d  = 1'b0;
            pr_on_tx_d = 1'b0;
        end
        if ((state_q == S_IDLE) && pr_full_q && !pr_on_tx_q && !tx_valid_q) begin
            tx_valid_d = 1'b1;
            tx_data_d  = pr_data_q;
            pr_on_tx_d = 1'b1;
        end
        if (print_valid) begin
            if (!pr_full_q || pr_sent_c) begin
                pr_full_d = 1'b1;
                pr_data_d = print_value;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end
`endif

        rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            is_rd_q    <= 1'b0;
            lat_q      <= '0;
            rbuf_q     <= 32'd0;
            rcnt_q     <= 3'd0;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'd0;
            sel_q      <= 1'b0;
            wren_q     <= 1'b0;
            rden_q     <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            cmd_err_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef LOADER_PRINT_FWD_EN
            pr_full_q  <= 1'b0;
            pr_on_tx_q <= 1'b0;
            pr_data_q  <= 8'd0;
            drop_q     <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_rd_q    <= is_rd_d;
            lat_q      <= lat_d;
            rbuf_q     <= rbuf_d;
            rcnt_q     <= rcnt_d;
            rx_ready_q <= rx_ready_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            sel_q      <= sel_d;
            wren_q     <= wren_d;
            rden_q     <= rden_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cmd_err_q  <= cmd_err_d;
            busy_q     <= busy_d;
`ifdef LOADER_PRINT_FWD_EN
            pr_full_q  <= pr_full_d;
            pr_on_tx_q <= pr_on_tx_d;
            pr_data_q  <= pr_data_d;
            drop_q     <= drop_d;
`endif
        end
    end

    assign rx_ready   = rx_ready_q;
    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign conf_sel   = sel_q;
    assign conf_wren  = wren_q;
    assign conf_rden  = rden_q;
    assign conf_addr  = addr_q;
    assign conf_wdata = wdata_q;
    assign cmd_err    = cmd_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_conf_loader.sv
// Scoreboard bench for conf_loader: tx bytes and write strobes checked against queues.
module tb_conf_loader;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic        conf_sel, conf_wren, conf_rden;
    logic [31:0] conf_addr, conf_wdata;
    logic [31:0] conf_rdata = 32'h0BAD_0BAD;
    logic        print_valid = 1'b0;
    logic [7:0]  print_value = 8'd0;
    logic        cmd_err, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int tx_mode = 0;
    int wren_cnt = 0, rden_cnt = 0, err_cnt = 0;
    int unexpected_tx = 0, unexpected_wr = 0, hold_err = 0;
    logic       hold_prev = 1'b0;
    logic [7:0] prev_data = 8'd0;

    logic [7:0]  exp_q[$];
    logic [63:0] wr_q[$];
    logic [31:0] mem    [0:255];
    logic [31:0] tbmem  [0:255];

    conf_loader #(.RD_LAT(1)) dut (
        .clk(clk), .resetn(resetn),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .conf_sel(conf_sel), .conf_wren(conf_wren), .conf_rden(conf_rden),
        .conf_addr(conf_addr), .conf_wdata(conf_wdata), .conf_rdata(conf_rdata),
        .print_valid(print_valid), .print_value(print_value),
        .cmd_err(cmd_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: data valid only in the cycle after the read strobe
    always @(posedge clk) begin
        if (conf_wren) mem[conf_addr[7:0]] <= conf_wdata;
        if (conf_rden) conf_rdata <= mem[conf_addr[7:0]];
        else           conf_rdata <= 32'h0BAD_0BAD;
    end

    always @(posedge clk) begin
        #1;
        case (tx_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ~tx_ready;
            2: tx_ready = 1'b0;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: scoreboard pops, strobe counts, tx hold stability
    always @(negedge clk) begin
        logic [7:0]  eb;
        logic [63:0] ew;
        if (hold_prev && (!tx_valid || tx_data != prev_data)) hold_err++;
        hold_prev = tx_valid & ~tx_ready;
        prev_data = tx_data;
        if (tx_valid && tx_ready) begin
            if (exp_q.size() > 0) begin
                eb = exp_q.pop_front();
                check_eq("tx_byte", 32'(tx_data), 32'(eb));
            end else begin
                unexpected_tx++;
            end
        end
        if (conf_wren) begin
            wren_cnt++;
            if (wr_q.size() > 0) begin
                ew = wr_q.pop_front();
                check_eq("wr_addr", conf_addr, ew[63:32]);
                check_eq("wr_data", conf_wdata, ew[31:0]);
            end else begin
                unexpected_wr++;
            end
        end
        if (conf_rden) rden_cnt++;
        if (cmd_err)   err_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        bit ok;
        rx_valid = 1'b1;
        rx_data  = b;
        ok = 1'b0;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (rx_ready) begin ok = 1'b1; break; end
        end
        check_eq("rx_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d, input bit expect_strobe);
        if (expect_strobe) begin
            wr_q.push_back({a, d});
            tbmem[a[7:0]] = d;
        end
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
        idle_cycles(3);
    endtask

    task automatic send_read(input logic [31:0] a, input bit expect_resp);
        logic [31:0] v;
        int n;
        v = tbmem[a[7:0]];
        if (expect_resp) for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
        send_byte(8'h02);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check_eq("resp_drain", 32'(exp_q.size()), 32'd0);
        idle_cycles(4);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
        check_eq({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
        check_eq({tag, "_tx_data"},   32'(tx_data),   32'd0);
        check_eq({tag, "_sel"},       32'(conf_sel),  32'd0);
        check_eq({tag, "_wren"},      32'(conf_wren), 32'd0);
        check_eq({tag, "_rden"},      32'(conf_rden), 32'd0);
        check_eq({tag, "_addr"},      conf_addr,      32'd0);
        check_eq({tag, "_wdata"},     conf_wdata,     32'd0);
        check_eq({tag, "_cmd_err"},   32'(cmd_err),   32'd0);
        check_eq({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        int w0, r0, e0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rx_ready_after_rst", 32'(rx_ready), 32'd1);

        send_byte(8'h03);
        idle_cycles(1);
        check_eq("sel_on", 32'(conf_sel), 32'd1);

        w0 = wren_cnt;
        send_write(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        check_eq("wren_once", 32'(wren_cnt - w0), 32'd1);
        check_eq("addr_hold", conf_addr, 32'h0000_0010);
        check_eq("wdata_hold", conf_wdata, 32'hDEAD_BEEF);

        r0 = rden_cnt;
        tx_mode = 0;
        send_read(32'h0000_0010, 1'b1);
        check_eq("rden_once", 32'(rden_cnt - r0), 32'd1);
        tx_mode = 1;
        send_read(32'h0000_0010, 1'b1);
        send_write(32'h0000_0011, 32'h0123_4567, 1'b1);
        tx_mode = 3;
        send_read(32'h0000_0011, 1'b1);
        send_read(32'h0000_0010, 1'b1);
        tx_mode = 0;

        send_byte(8'h04);
        idle_cycles(1);
        check_eq("sel_off", 32'(conf_sel), 32'd0);
        w0 = wren_cnt; e0 = err_cnt; r0 = rden_cnt;
        send_write(32'h0000_0020, 32'h1111_2222, 1'b0);
        check_eq("nosel_wr_no_wren", 32'(wren_cnt - w0), 32'd0);
        check_eq("nosel_wr_err", 32'(err_cnt - e0), 32'd1);
        send_read(32'h0000_0010, 1'b0);
        check_eq("nosel_rd_no_rden", 32'(rden_cnt - r0), 32'd0);
        check_eq("nosel_rd_err", 32'(err_cnt - e0), 32'd2);
        send_byte(8'h03);
        idle_cycles(1);
        check_eq("sel_on_after_err", 32'(conf_sel), 32'd1);
        check_eq("sel_on_no_err", 32'(err_cnt - e0), 32'd2);

        e0 = err_cnt;
        send_byte(8'h7F);
        idle_cycles(2);
        check_eq("bad_op_err", 32'(err_cnt - e0), 32'd1);
        check_eq("bad_op_busy", 32'(busy), 32'd0);
        check_eq("bad_op_ready", 32'(rx_ready), 32'd1);

        r0 = rden_cnt;
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h00);
        check_eq("mid_busy", 32'(busy), 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check_reset_vals("mid");
        resetn = 1'b1;
        idle_cycles(3);
        check_eq("mid_no_rden", 32'(rden_cnt - r0), 32'd0);
        send_byte(8'h03);
        idle_cycles(1);
        tbmem[8'h10] = mem[8'h10];
        send_read(32'h0000_0010, 1'b1);
        check_eq("post_rst_mem", tbmem[8'h10], 32'hDEAD_BEEF);

`ifdef LOADER_PRINT_FWD_EN
        send_byte(8'h04);
        idle_cycles(1);
        tx_mode = 2;
        idle_cycles(2);
        print_valid = 1'b1;
        print_value = 8'h48;
        @(posedge clk); #1;
        print_value = 8'h49;
        @(posedge clk); #1;
        print_valid = 1'b0;
        idle_cycles(3);
        check_eq("pr_tx_valid", 32'(tx_valid), 32'd1);
        check_eq("pr_tx_data", 32'(tx_data), 32'h48);
        check_eq("pr_drop", 32'(dut.drop_q), 32'd1);
        exp_q.push_back(8'h48);
        tx_mode = 0;
        idle_cycles(6);
        check_eq("pr_sent", 32'(exp_q.size()), 32'd0);
        check_eq("pr_tx_idle", 32'(tx_valid), 32'd0);
`endif

        idle_cycles(2);
        check_eq("unexpected_tx", 32'(unexpected_tx), 32'd0);
        check_eq("unexpected_wr", 32'(unexpected_wr), 32'd0);
        check_eq("tx_hold", 32'(hold_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
